// File: rtl/bram_capture_ctrl.sv
// Pre/post-trigger capture controller writing packed ADC samples into a BRAM ring.
// Latency: din/din_valid at cycle n appear as wdata/waddr/w_ena at cycle n+1.
// Backpressure: none; every strobe accepted while capturing is written, the BRAM never stalls.
//
// Ports:
//   wclk, reset_n            capture clock, asynchronous active-low reset
//   start/abort/trig         arm (rising edge), cancel (level, top priority), trigger (level)
//   pre_len/post_len         record lengths, latched on the arming edge (post_len 0 = full depth)
//   din/din_valid            packed channel samples (ch0 in LSBs) and their strobe
//   waddr/wdata/w_ena        registered BRAM write port
//   busy/status/done         capture in progress, its complement, capture complete
//   trig_addr/first_addr     address of first post-trigger sample and of oldest valid sample
module bram_capture_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DW     = 14,
    parameter int NCH    = 2
) (
    input  logic                wclk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                trig,
    input  logic [ADDR_W-1:0]   pre_len,
    input  logic [ADDR_W-1:0]   post_len,
    input  logic [NCH*DW-1:0]   din,
    input  logic                din_valid,
    output logic [ADDR_W-1:0]   waddr,
    output logic [NCH*DW-1:0]   wdata,
    output logic                w_ena,
    output logic                busy,
    output logic                status,
    output logic                done,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic [ADDR_W-1:0]   first_addr
);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 start_q;
    logic [ADDR_W-1:0]    pre_len_q, pre_len_d;
    logic [ADDR_W:0]      post_len_q, post_len_d;
    logic [ADDR_W:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic [ADDR_W-1:0]    trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]    first_addr_q, first_addr_d;
    logic                 pend_q, pend_d;
    logic                 accept;
    logic                 start_edge;
    logic                 busy_d;
    logic [ADDR_W-1:0]    waddr_q;
    logic [NCH*DW-1:0]    wdata_q;
    logic                 w_ena_q, busy_q, status_q, done_q;

    // start_q resets high so a start level held through reset release is not an edge.
    assign start_edge = start & ~start_q;

    always_comb begin
        state_d      = state_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        cnt_d        = cnt_q;
        wptr_d       = wptr_q;
        trig_addr_d  = trig_addr_q;
        first_addr_d = first_addr_q;
        pend_d       = pend_q;
        accept       = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_edge) begin
                        pre_len_d  = pre_len;
                        // Zero post length means a full ring; the extra counter bit holds 2**ADDR_W.
                        post_len_d = {(post_len == '0), post_len};
                        wptr_d     = '0;
                        cnt_d      = '0;
                        pend_d     = 1'b0;
                        state_d    = (pre_len != '0) ? PRE : ARMED;
                    end
                end
                PRE: begin
                    if (din_valid) begin
                        accept = 1'b1;
                        cnt_d  = cnt_q + CNT_ONE;
                        if (cnt_d == {1'b0, pre_len_q}) begin
                            cnt_d   = '0;
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    accept = din_valid;
                    if (trig) begin
                        state_d = POST;
                        if (din_valid) begin
                            // The trigger-cycle sample is the first post-trigger sample.
                            trig_addr_d = wptr_q;
                            cnt_d       = CNT_ONE;
                            if (post_len_q == CNT_ONE) begin
                                state_d      = DONE;
                                first_addr_d = wptr_q - pre_len_q;
                            end
                        end else begin
                            // Trigger waits for the next valid sample to pin its address.
                            pend_d = 1'b1;
                            cnt_d  = '0;
                        end
                    end
                end
                POST: begin
                    if (din_valid) begin
                        accept = 1'b1;
                        if (pend_q) begin
                            trig_addr_d = wptr_q;
                            pend_d      = 1'b0;
                        end
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == post_len_q) begin
                            state_d      = DONE;
                            first_addr_d = trig_addr_d - pre_len_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            wptr_d = wptr_q + PTR_ONE;
        end
    end

    // Status flags are registered from the next state so they line up with state_q.
    assign busy_d = (state_d == PRE) || (state_d == ARMED) || (state_d == POST);

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b1;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            trig_addr_q  <= '0;
            first_addr_q <= '0;
            pend_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            w_ena_q      <= 1'b0;
            busy_q       <= 1'b0;
            status_q     <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            trig_addr_q  <= trig_addr_d;
            first_addr_q <= first_addr_d;
            pend_q       <= pend_d;
            w_ena_q      <= accept;
            if (accept) begin
                waddr_q <= wptr_q;
                wdata_q <= din;
            end
            busy_q       <= busy_d;
            status_q     <= ~busy_d;
            done_q       <= (state_d == DONE);
        end
    end

    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign w_ena      = w_ena_q;
    assign busy       = busy_q;
    assign status     = status_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign first_addr = first_addr_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl with a 16-deep ring.
// Latency: outputs sampled on the falling edge after each active edge.
// Backpressure: not applicable; stimulus is a per-cycle table replayed into the DUT.
module tb_bram_capture_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 14;
    localparam int NCH   = 2;
    localparam int W     = NCH * DW;
    localparam int DEPTH = 1 << AW;
    localparam int MAXC  = 600;

    logic          wclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b1;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic          din_valid = 1'b0;
    logic [AW-1:0] pre_len = '0;
    logic [AW-1:0] post_len = '0;
    logic [W-1:0]  din = '0;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          w_ena;
    logic          busy;
    logic          status;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] first_addr;

    bram_capture_ctrl #(.ADDR_W(AW), .DW(DW), .NCH(NCH)) dut (
        .wclk(wclk), .reset_n(reset_n), .start(start), .abort(abort), .trig(trig),
        .pre_len(pre_len), .post_len(post_len), .din(din), .din_valid(din_valid),
        .waddr(waddr), .wdata(wdata), .w_ena(w_ena), .busy(busy), .status(status),
        .done(done), .trig_addr(trig_addr), .first_addr(first_addr)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_bad = 0;

    // Per-cycle stimulus table; cycle 0 carries the arming start edge.
    bit           vld_a [MAXC];
    bit           tr_a  [MAXC];
    logic [W-1:0] d_a   [MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // duty 0 = every cycle valid, otherwise valid with probability 1/duty.
    task automatic fill_stim(input int duty, input int trig_pct);
        for (int c = 0; c < MAXC; c++) begin
            vld_a[c] = (duty == 0) ? 1'b1 : ($urandom_range(0, duty - 1) == 0);
            tr_a[c]  = ($urandom_range(0, 99) < trig_pct);
            if (c >= 150) tr_a[c] = 1'b1;
            if (c >= 400) vld_a[c] = 1'b1;
            d_a[c]   = W'($urandom);
        end
    endtask

    task automatic clear_trig();
        for (int c = 0; c < MAXC; c++) tr_a[c] = 1'b0;
    endtask

    // Reference: walk the table by capture phase (pre history, trigger search, post record)
    // to get the expected write list and reported addresses, then replay and compare.
    task automatic run_capture(input int pre, input int post, input string name);
        int           exp_addr[$];
        logic [W-1:0] exp_dat[$];
        int           got_addr[$];
        logic [W-1:0] got_dat[$];
        int pre_seen   = 0;
        int armed_from = -1;
        int trig_c     = -1;
        int post_seen  = 0;
        int done_c     = -1;
        int n_wr       = 0;
        int t_addr     = 0;
        int fa;
        int post_n     = (post == 0) ? DEPTH : post;
        int n_cmp;

        if (pre == 0) armed_from = 1;
        for (int c = 1; c < MAXC && done_c < 0; c++) begin
            if (armed_from >= 0 && trig_c < 0 && c >= armed_from && tr_a[c]) trig_c = c;
            if (vld_a[c]) begin
                if (trig_c >= 0 && post_seen == 0) t_addr = n_wr % DEPTH;
                exp_addr.push_back(n_wr % DEPTH);
                exp_dat.push_back(d_a[c]);
                n_wr++;
                if (trig_c >= 0) begin
                    post_seen++;
                    if (post_seen == post_n) done_c = c;
                end else if (armed_from < 0) begin
                    pre_seen++;
                    if (pre_seen == pre) armed_from = c + 1;
                end
            end
        end
        fa = (t_addr - pre + DEPTH) % DEPTH;
        if (done_c < 0) done_c = MAXC - 4;

        @(negedge wclk);
        start     = 1'b0;
        din_valid = 1'b0;
        trig      = 1'b0;
        abort     = 1'b0;
        pre_len   = AW'(pre);
        post_len  = AW'(post);
        for (int c = 0; c <= done_c + 3; c++) begin
            @(negedge wclk);
            if (c >= 1) begin
                if (w_ena) begin
                    got_addr.push_back(int'(waddr));
                    got_dat.push_back(wdata);
                end
                check_eq({name, ":busy"},   32'(busy),   32'((c - 1) < done_c));
                check_eq({name, ":done"},   32'(done),   32'((c - 1) >= done_c));
                check_eq({name, ":status"}, 32'(status), 32'((c - 1) >= done_c));
            end
            start     = 1'b1;
            din_valid = vld_a[c];
            trig      = tr_a[c];
            din       = d_a[c];
            // Lengths matter only on the arming edge; scramble them afterwards.
            if (c == 1) begin
                pre_len  = AW'($urandom);
                post_len = AW'($urandom);
            end
        end
        check_eq({name, ":n_writes"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n_cmp = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n_cmp; i++) begin
            check_eq({name, ":waddr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            check_eq({name, ":wdata"}, 32'(got_dat[i]),  32'(exp_dat[i]));
        end
        check_eq({name, ":trig_addr"},  32'(trig_addr),  32'(t_addr));
        check_eq({name, ":first_addr"}, 32'(first_addr), 32'(fa));
        check_eq({name, ":w_ena_after"}, 32'(w_ena), 32'(0));
    endtask

    initial begin
        // Reset values, with start held high across reset release.
        @(negedge wclk);
        @(negedge wclk);
        check_eq("rst:waddr",      32'(waddr),      32'(0));
        check_eq("rst:wdata",      32'(wdata),      32'(0));
        check_eq("rst:w_ena",      32'(w_ena),      32'(0));
        check_eq("rst:busy",       32'(busy),       32'(0));
        check_eq("rst:status",     32'(status),     32'(1));
        check_eq("rst:done",       32'(done),       32'(0));
        check_eq("rst:trig_addr",  32'(trig_addr),  32'(0));
        check_eq("rst:first_addr", 32'(first_addr), 32'(0));
        reset_n   = 1'b1;
        din_valid = 1'b1;
        trig      = 1'b1;
        pre_len   = 4'd2;
        post_len  = 4'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge wclk);
            check_eq("held_start:busy",  32'(busy),  32'(0));
            check_eq("held_start:w_ena", 32'(w_ena), 32'(0));
        end
        start = 1'b0;
        @(negedge wclk);
        start = 1'b1;
        @(negedge wclk);
        check_eq("rearm:busy",   32'(busy),   32'(1));
        check_eq("rearm:status", 32'(status), 32'(0));
        abort = 1'b1;
        @(negedge wclk);
        abort = 1'b0;
        check_eq("abort_pre:busy", 32'(busy), 32'(0));

        // Directed: pre 3, post 4, always valid, trigger on the 10th accepted sample.
        fill_stim(0, 0);
        clear_trig();
        tr_a[10] = 1'b1;
        run_capture(3, 4, "basic");

        // Directed: zero lengths -> full ring post record triggered at once.
        fill_stim(0, 0);
        clear_trig();
        tr_a[1] = 1'b1;
        run_capture(0, 0, "full_ring");

        // Directed: trigger during pre phase ignored, later pulse accepted.
        fill_stim(0, 0);
        clear_trig();
        for (int c = 1; c <= 5; c++) tr_a[c] = 1'b1;
        tr_a[12] = 1'b1;
        run_capture(5, 3, "pre_trig");

        // Directed: 1-of-3 strobe, trigger raised on a non-valid cycle.
        fill_stim(0, 0);
        clear_trig();
        for (int c = 0; c < MAXC; c++) vld_a[c] = ((c % 3) == 1);
        tr_a[9] = 1'b1;
        run_capture(2, 3, "sparse");

        // Directed: abort in POST with a coincident start edge.
        @(negedge wclk);
        start = 1'b0; din_valid = 1'b1; trig = 1'b0; pre_len = 4'd2; post_len = 4'd10;
        for (int c = 0; c <= 16; c++) begin
            @(negedge wclk);
            if (c == 10) check_eq("abort:busy_before", 32'(busy), 32'(1));
            if (c == 11) begin
                check_eq("abort:busy",   32'(busy),   32'(0));
                check_eq("abort:done",   32'(done),   32'(0));
                check_eq("abort:status", 32'(status), 32'(1));
            end
            if (c >= 12) begin
                check_eq("abort:idle_busy",  32'(busy),  32'(0));
                check_eq("abort:idle_w_ena", 32'(w_ena), 32'(0));
            end
            start = (c != 9);
            trig  = (c == 4);
            abort = (c == 10);
            din   = W'($urandom);
        end

        // Randomized captures.
        for (int r = 0; r < 20; r++) begin
            fill_stim($urandom_range(0, 3), $urandom_range(2, 40));
            run_capture($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
